// File: rtl/bcd_6d_to_binary_seq.sv
// Sequential packed-BCD to binary converter using reverse double-dabble,
// one bit per clock behind a start/ready/done handshake.
module bcd_6d_to_binary_seq #(
  parameter int NDIG = 6,
  parameter int NBIN = 20
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [NDIG*4-1:0] bcd_i,
  output logic              ready,
  output logic              done,
  output logic [NBIN-1:0]   bin_o,
  output logic              err
);

  localparam int BW = NDIG * 4;
  localparam int SW = BW + NBIN;
  localparam int CW = $clog2(NBIN + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(NBIN - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ERR,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   sr_q, sr_d;
  logic [NBIN-1:0] bin_q, bin_d;
  logic            err_q, err_d;

  logic [SW-1:0]   sr_shift;
  logic [BW-1:0]   bcd_adj;
  logic [NDIG-1:0] dig_bad;

  // {bcd,bin} shifted right: the BCD LSB falls into the binary MSB.
  assign sr_shift = sr_q >> 1;

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
    logic [3:0] dig;
    assign dig                = sr_shift[NBIN + 4*gi +: 4];
    assign bcd_adj[4*gi +: 4] = (dig >= 4'd8) ? (dig - 4'd3) : dig;
    assign dig_bad[gi]        = (bcd_i[4*gi +: 4] > 4'd9);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {bcd_i, {NBIN{1'b0}}};
          cnt_d   = '0;
          state_d = (|dig_bad) ? ERR : SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = {bcd_adj, sr_shift[NBIN-1:0]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          bin_d   = sr_shift[NBIN-1:0];
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      ERR: begin
        bin_d   = '0;
        err_d   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign bin_o = bin_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd_6d_to_binary_seq.sv
// Scoreboard bench for bcd_6d_to_binary_seq: stimulus pushes decimal-model
// expectations, an independent monitor pops and checks on every done pulse.
module tb_bcd_6d_to_binary_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [23:0] bcd_i;
  logic        ready;
  logic        done;
  logic [19:0] bin_o;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cnt = 0;
  int done_cnt = 0;
  logic rst_at_edge = 1'b0;

  logic [19:0] exp_bin_q[$];
  logic        exp_err_q[$];
  int          exp_start_q[$];
  int          exp_lat_q[$];

  logic [19:0] last_bin = '0;
  logic        last_err = 1'b0;
  logic        prev_done = 1'b0;

  bcd_6d_to_binary_seq #(.NDIG(6), .NBIN(20)) dut (
    .clk  (clk),
    .rstn (rstn),
    .start(start),
    .bcd_i(bcd_i),
    .ready(ready),
    .done (done),
    .bin_o(bin_o),
    .err  (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= !rstn;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: plain decimal weighting of the digits.
  task automatic model(input logic [23:0] v, output logic [19:0] b, output logic e);
    int s;
    int p;
    int d;
    s = 0;
    p = 1;
    e = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) e = 1'b1;
      s = s + d * p;
      p = p * 10;
    end
    b = e ? 20'd0 : s[19:0];
  endtask

  function automatic logic [23:0] rand_bcd();
    logic [23:0] v;
    for (int i = 0; i < 6; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Called at a negedge where ready=1 and start=1 is being presented.
  task automatic push_exp(input logic [23:0] v);
    logic [19:0] b;
    logic        e;
    model(v, b, e);
    exp_bin_q.push_back(b);
    exp_err_q.push_back(e);
    exp_start_q.push_back(cyc + 1);
    exp_lat_q.push_back(e ? 1 : 20);
    accept_cnt++;
  endtask

  task automatic issue(input logic [23:0] v);
    int w;
    w = 0;
    @(negedge clk);
    while (!ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got=0 want=1");
    end else begin
      start = 1'b1;
      bcd_i = v;
      push_exp(v);
      @(negedge clk);
      start = 1'b0;
      bcd_i = 24'($urandom);
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (!(exp_bin_q.size() == 0 && ready) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (exp_bin_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=%0d want=0", exp_bin_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (rst_at_edge) begin
      chk("rst_bin", 32'(bin_o), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      last_bin  = '0;
      last_err  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("ready_after_done", 32'(ready), 32'd1);
      if (done) begin
        done_cnt++;
        chk("ready_in_done", 32'(ready), 32'd0);
        if (exp_bin_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got=%0h want=none", bin_o);
        end else begin
          logic [19:0] eb;
          logic        ee;
          int          st;
          int          lat;
          eb  = exp_bin_q.pop_front();
          ee  = exp_err_q.pop_front();
          st  = exp_start_q.pop_front();
          lat = exp_lat_q.pop_front();
          $display("txn %0d bin_o=%05h err=%0b latency=%0d", done_cnt, bin_o, err, cyc - st);
          chk("bin_o", 32'(bin_o), 32'(eb));
          chk("err", 32'(err), 32'(ee));
          chk("latency", 32'(cyc - st), 32'(lat));
        end
        last_bin = bin_o;
        last_err = err;
      end else begin
        chk("bin_hold", 32'(bin_o), 32'(last_bin));
        chk("err_hold", 32'(err), 32'(last_err));
      end
      prev_done = done;
    end
  end

  initial begin
    logic [23:0] held_vals [3];
    int k;
    held_vals[0] = 24'h500000;
    held_vals[1] = 24'h000042;
    held_vals[2] = 24'h123456;

    rstn  = 1'b0;
    start = 1'b0;
    bcd_i = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    issue(24'h999999);
    wait_idle();

    issue(24'h000000);
    issue(24'h000123);
    wait_idle();

    issue(24'h00A000);
    issue(24'h000010);
    wait_idle();

    // start held high: only the value present on each accepting edge counts
    k = 0;
    @(negedge clk);
    start = 1'b1;
    while (k < 3) begin
      if (ready) begin
        bcd_i = held_vals[k];
        push_exp(held_vals[k]);
        k++;
      end else begin
        bcd_i = 24'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();

    // reset mid-conversion: the in-flight result is discarded
    issue(24'h654321);
    repeat (9) @(negedge clk);
    rstn = 1'b0;
    void'(exp_bin_q.pop_back());
    void'(exp_err_q.pop_back());
    void'(exp_start_q.pop_back());
    void'(exp_lat_q.pop_back());
    accept_cnt--;
    @(negedge clk);
    rstn = 1'b1;
    issue(24'h654321);
    wait_idle();

    for (int n = 0; n < 1000; n++) issue(rand_bcd());
    wait_idle();
    repeat (3) @(negedge clk);

    chk("done_count", 32'(done_cnt), 32'(accept_cnt));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
